ternary_neuron_accum: RTL and testbench

Sequential accumulate-and-threshold stage that sits directly downstream of the 16-input approximate popcount units. Each beat carries two popcounts: active inputs on positive-weight synapses and active inputs on negative-weight synapses, for one 16-input slice of a ternary neuron. The block sums (pos − neg) over the slices of one neuron and compares the total against two thresholds. It emits one ternary activation per neuron over a valid/ready handshake.

---
 rtl/ternary_neuron_accum.sv | 127 ++++++++++++
 tb/tb_ternary_neuron_accum.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ternary_neuron_accum.sv
// Accumulates signed (pos - neg) popcount differences over the slices of one
// ternary neuron and emits a thresholded activation over a valid/ready handshake.
module ternary_neuron_accum #(
  parameter int MAX_CHUNKS = 4,
  parameter int ACC_W      = 10,
  parameter int T_HI       = 4,
  parameter int T_LO       = -4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       pc_pos,
  input  logic [4:0]       pc_neg,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_act,
  output logic [ACC_W-1:0] out_sum,
  output logic             overrun
);

  localparam int CNT_W = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CHUNKS - 1);
  localparam logic signed [ACC_W-1:0] THI = ACC_W'(T_HI);
  localparam logic signed [ACC_W-1:0] TLO = ACC_W'(T_LO);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic MULTI = (MAX_CHUNKS > 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     out_valid_q, out_valid_d;
  logic [1:0]               out_act_q, out_act_d;
  logic [ACC_W-1:0]         out_sum_q, out_sum_d;
  logic                     overrun_q, overrun_d;

  logic                     accept;
  logic                     cap;
  logic                     terminal;
  logic signed [5:0]        diff;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W:0]    sum_wide;
  logic signed [ACC_W-1:0]  acc_next;

  assign in_ready  = !out_valid_q | out_ready;
  assign out_valid = out_valid_q;
  assign out_act   = out_act_q;
  assign out_sum   = out_sum_q;
  assign overrun   = overrun_q;

  always_comb begin
    accept   = in_valid & in_ready;
    cap      = (cnt_q == CNT_LAST);
    terminal = in_last | cap;
    diff     = {1'b0, pc_pos} - {1'b0, pc_neg};
    acc_base = (state_q == IDLE) ? '0 : acc_q;
    // One guard bit detects overflow; clamp instead of wrapping.
    sum_wide = {acc_base[ACC_W-1], acc_base} + {{(ACC_W-5){diff[5]}}, diff};
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      acc_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next = sum_wide[ACC_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_act_d   = out_act_q;
    out_sum_d   = out_sum_q;
    overrun_d   = overrun_q;
    if (accept) begin
      // Any accepted beat also completes a pending output handshake.
      out_valid_d = 1'b0;
      state_d     = ACCUM;
      acc_d       = acc_next;
      cnt_d       = cnt_q + CNT_W'(1);
      if (terminal) begin
        state_d     = HOLD;
        acc_d       = '0;
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_sum_d   = acc_next;
        if (acc_next >= THI) begin
          out_act_d = 2'b01;
        end else if (acc_next <= TLO) begin
          out_act_d = 2'b11;
        end else begin
          out_act_d = 2'b00;
        end
        if (MULTI && cap && !in_last) begin
          overrun_d = 1'b1;
        end
      end
    end else if (out_valid_q && out_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_act_q   <= 2'b00;
      out_sum_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_act_q   <= out_act_d;
      out_sum_q   <= out_sum_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_ternary_neuron_accum.sv
// Directed bench for ternary_neuron_accum: default, narrow-accumulator and
// single-chunk instances share one stimulus stream.
module tb_ternary_neuron_accum;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] pc_pos = '0;
  logic [4:0] pc_neg = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic       a_in_ready, a_out_valid, a_overrun;
  logic [1:0] a_out_act;
  logic [9:0] a_out_sum;
  logic       s_in_ready, s_out_valid, s_overrun;
  logic [1:0] s_out_act;
  logic [5:0] s_out_sum;
  logic       o_in_ready, o_out_valid, o_overrun;
  logic [1:0] o_out_act;
  logic [9:0] o_out_sum;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ternary_neuron_accum #(.MAX_CHUNKS(4), .ACC_W(10), .T_HI(4), .T_LO(-4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .pc_pos(pc_pos), .pc_neg(pc_neg), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_act(a_out_act),
    .out_sum(a_out_sum), .overrun(a_overrun));

  ternary_neuron_accum #(.MAX_CHUNKS(4), .ACC_W(6), .T_HI(4), .T_LO(-4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .pc_pos(pc_pos), .pc_neg(pc_neg), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_act(s_out_act),
    .out_sum(s_out_sum), .overrun(s_overrun));

  ternary_neuron_accum #(.MAX_CHUNKS(1), .ACC_W(10), .T_HI(4), .T_LO(-4)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_in_ready),
    .pc_pos(pc_pos), .pc_neg(pc_neg), .in_last(in_last),
    .out_valid(o_out_valid), .out_ready(out_ready), .out_act(o_out_act),
    .out_sum(o_out_sum), .overrun(o_overrun));

  task automatic apply_reset();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    pc_pos    = '0;
    pc_neg    = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive_beat(input logic [4:0] p, input logic [4:0] n, input logic last);
    pc_pos   = p;
    pc_neg   = n;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (a_out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", a_out_valid); else passed++;
    total++; if (a_out_act !== 2'b00) $display("FAIL reset_act: got %b expected 00", a_out_act); else passed++;
    total++; if (a_out_sum !== 10'd0) $display("FAIL reset_sum: got %0d expected 0", a_out_sum); else passed++;
    total++; if (a_overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", a_overrun); else passed++;
    total++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive_beat(5'd9, 5'd2, 1'b1);
    total++; if (a_out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", a_out_valid); else passed++;
    total++; if (a_out_sum !== 10'd7) $display("FAIL single_sum: got %0d expected 7", $signed(a_out_sum)); else passed++;
    total++; if (a_out_act !== 2'b01) $display("FAIL single_act: got %b expected 01", a_out_act); else passed++;
    consume();
    total++; if (a_out_valid !== 1'b0) $display("FAIL single_drop: got %b expected 0", a_out_valid); else passed++;
  endtask

  task automatic test_multi();
    drive_beat(5'd3, 5'd5, 1'b0);
    total++; if (a_out_valid !== 1'b0) $display("FAIL multi_mid_valid: got %b expected 0", a_out_valid); else passed++;
    drive_beat(5'd4, 5'd4, 1'b0);
    drive_beat(5'd1, 5'd3, 1'b1);
    total++; if (a_out_valid !== 1'b1) $display("FAIL multi_valid: got %b expected 1", a_out_valid); else passed++;
    total++; if (a_out_sum !== 10'h3FC) $display("FAIL multi_sum: got %0d expected -4", $signed(a_out_sum)); else passed++;
    total++; if (a_out_act !== 2'b11) $display("FAIL multi_act: got %b expected 11", a_out_act); else passed++;
    consume();
    drive_beat(5'd3, 5'd5, 1'b0);
    drive_beat(5'd4, 5'd4, 1'b0);
    drive_beat(5'd1, 5'd2, 1'b1);
    total++; if (a_out_sum !== 10'h3FD) $display("FAIL multi_var_sum: got %0d expected -3", $signed(a_out_sum)); else passed++;
    total++; if (a_out_act !== 2'b00) $display("FAIL multi_var_act: got %b expected 00", a_out_act); else passed++;
    consume();
  endtask

  task automatic test_overrun();
    apply_reset();
    for (int i = 0; i < 3; i++) drive_beat(5'd16, 5'd0, 1'b0);
    total++; if (a_out_valid !== 1'b0) $display("FAIL ovr_early_valid: got %b expected 0", a_out_valid); else passed++;
    total++; if (a_overrun !== 1'b0) $display("FAIL ovr_early_flag: got %b expected 0", a_overrun); else passed++;
    drive_beat(5'd16, 5'd0, 1'b0);
    total++; if (a_out_valid !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", a_out_valid); else passed++;
    total++; if (a_out_sum !== 10'd64) $display("FAIL ovr_sum: got %0d expected 64", $signed(a_out_sum)); else passed++;
    total++; if (a_out_act !== 2'b01) $display("FAIL ovr_act: got %b expected 01", a_out_act); else passed++;
    total++; if (a_overrun !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", a_overrun); else passed++;
    out_ready = 1'b1;
    drive_beat(5'd16, 5'd0, 1'b0);
    out_ready = 1'b0;
    total++; if (a_out_valid !== 1'b0) $display("FAIL ovr_fifth_valid: got %b expected 0", a_out_valid); else passed++;
    drive_beat(5'd0, 5'd0, 1'b1);
    total++; if (a_out_sum !== 10'd16) $display("FAIL ovr_new_sum: got %0d expected 16", $signed(a_out_sum)); else passed++;
    total++; if (a_overrun !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", a_overrun); else passed++;
    consume();
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 4; i++) drive_beat(5'd31, 5'd0, 1'b0);
    total++; if (s_out_valid !== 1'b1) $display("FAIL sat_valid: got %b expected 1", s_out_valid); else passed++;
    total++; if (s_out_sum !== 6'd31) $display("FAIL sat_sum: got %0d expected 31", $signed(s_out_sum)); else passed++;
    total++; if (s_out_act !== 2'b01) $display("FAIL sat_act: got %b expected 01", s_out_act); else passed++;
    total++; if (a_out_sum !== 10'd124) $display("FAIL wide_sum: got %0d expected 124", $signed(a_out_sum)); else passed++;
    consume();
  endtask

  logic [4:0] bb_pos [3] = '{5'd9, 5'd0, 5'd3};
  logic [4:0] bb_neg [3] = '{5'd2, 5'd5, 5'd3};
  logic [9:0] bb_sum [3] = '{10'd7, 10'h3FB, 10'd0};
  logic [1:0] bb_act [3] = '{2'b01, 2'b11, 2'b00};

  task automatic test_back_to_back();
    apply_reset();
    out_ready = 1'b1;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_pos = bb_pos[i];
      pc_neg = bb_neg[i];
      @(posedge clk);
      #1;
      total++; if (o_out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b expected 1", i, o_out_valid); else passed++;
      total++; if (o_out_sum !== bb_sum[i]) $display("FAIL b2b_sum[%0d]: got %0d expected %0d", i, $signed(o_out_sum), $signed(bb_sum[i])); else passed++;
      total++; if (o_out_act !== bb_act[i]) $display("FAIL b2b_act[%0d]: got %b expected %b", i, o_out_act, bb_act[i]); else passed++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++; if (o_overrun !== 1'b0) $display("FAIL b2b_overrun: got %b expected 0", o_overrun); else passed++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    drive_beat(5'd9, 5'd2, 1'b1);
    pc_pos   = 5'd20;
    pc_neg   = 5'd0;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++; if (a_in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, a_in_ready); else passed++;
      total++; if (a_out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b expected 1", i, a_out_valid); else passed++;
      total++; if (a_out_sum !== 10'd7) $display("FAIL bp_sum[%0d]: got %0d expected 7", i, $signed(a_out_sum)); else passed++;
      total++; if (a_out_act !== 2'b01) $display("FAIL bp_act[%0d]: got %b expected 01", i, a_out_act); else passed++;
    end
    pc_pos    = 5'd1;
    pc_neg    = 5'd5;
    out_ready = 1'b1;
    #1;
    total++; if (a_in_ready !== 1'b1) $display("FAIL bp_ready_comb: got %b expected 1", a_in_ready); else passed++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++; if (a_out_valid !== 1'b1) $display("FAIL bp_replace_valid: got %b expected 1", a_out_valid); else passed++;
    total++; if (a_out_sum !== 10'h3FC) $display("FAIL bp_replace_sum: got %0d expected -4", $signed(a_out_sum)); else passed++;
    total++; if (a_out_act !== 2'b11) $display("FAIL bp_replace_act: got %b expected 11", a_out_act); else passed++;
    @(posedge clk);
    #1;
    total++; if (a_out_valid !== 1'b0) $display("FAIL bp_drain: got %b expected 0", a_out_valid); else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    out_ready = 1'b1;
    drive_beat(5'd9, 5'd2, 1'b1);
    drive_beat(5'd10, 5'd0, 1'b0);
    drive_beat(5'd10, 5'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (a_out_sum !== 10'd0) $display("FAIL rmid_sum: got %0d expected 0", $signed(a_out_sum)); else passed++;
    total++; if (a_out_act !== 2'b00) $display("FAIL rmid_act: got %b expected 00", a_out_act); else passed++;
    total++; if (o_out_valid !== 1'b0) $display("FAIL rmid_pending: got %b expected 0", o_out_valid); else passed++;
    total++; if (o_out_sum !== 10'd0) $display("FAIL rmid_pending_sum: got %0d expected 0", $signed(o_out_sum)); else passed++;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    drive_beat(5'd5, 5'd0, 1'b1);
    total++; if (a_out_valid !== 1'b1) $display("FAIL rmid_after_valid: got %b expected 1", a_out_valid); else passed++;
    total++; if (a_out_sum !== 10'd5) $display("FAIL rmid_after_sum: got %0d expected 5", $signed(a_out_sum)); else passed++;
    consume();
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_overrun();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
